// File: rtl/poly_add_sequencer.sv
// poly_add_sequencer
//   Control FSM for the Kyber encryption additions run through the shared
//   small-polynomial mux and CLA adder. Per job it performs, in order:
//     op 0..K-1 : u[j] = (A^T r)[j] + e1[j]
//     op K      : v'   = t^T r + e2
//     op K+1    : v    = v' + m
//   Each op walks ISSUE (add_start pulse) -> WAIT (until add_done) -> WRITE
//   (res_we pulse). After the last op a single done pulse is issued.
//
// Parameters
//   K          module rank, 2 or 3 (anything else stops elaboration)
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   start      job request, sampled only in IDLE
//   busy       high from the cycle after start is accepted until DONE exits
//   done       one-cycle job completion pulse
//   mux_sel    small-poly mux select: 0..3 small inputs, 4 = message m
//   b_sel      operand-B source: 0..K-1 A^T r row, K = t^T r, K+1 = v'
//   add_start  one-cycle adder launch pulse
//   add_done   adder completion pulse
//   res_we     one-cycle result write strobe
//   res_idx    destination: 0..K-1 u[j], K = v' scratch, K+1 = v
//   err        sticky WAIT timeout flag (watchdog build only, else 0)
//
// Build option
//   POLY_ADD_TIMEOUT_EN  adds a 10-bit WAIT watchdog; after 1023 WAIT cycles
//                        without add_done the job is abandoned and err set.
module poly_add_sequencer #(
  parameter int K = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] mux_sel,
  output logic [2:0] b_sel,
  output logic       add_start,
  input  logic       add_done,
  output logic       res_we,
  output logic [2:0] res_idx,
  output logic       err
);

  localparam int NUM_OPS = K + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_E2   = 3'(K);
  localparam logic [2:0] OP_M    = 3'(K + 1);
  localparam logic [2:0] LAST_OP = 3'(NUM_OPS - 1);

  generate
    if (K != 2 && K != 3) begin : g_bad_k
      $error("poly_add_sequencer: K must be 2 or 3");
    end
  endgenerate

  logic [2:0] r_state;
  logic [2:0] r_op;
  logic       w_timeout;
  logic       w_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ISSUE;
            r_op    <= '0;
          end
        end
        // add_done is deliberately not looked at here: adder latency >= 1,
        // so anything seen during ISSUE is stale or spurious.
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (add_done) begin
            r_state <= S_WRITE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (r_op == LAST_OP) begin
            r_state <= S_DONE;
          end else begin
            r_op    <= r_op + 3'd1;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_op    <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_op    <= '0;
        end
      endcase
    end
  end

  // All outputs decode purely from registered state/op, so they are glitch
  // free with respect to inputs, hold steady from ISSUE to WRITE and drop
  // to zero the instant rst is asserted.
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    add_start = (r_state == S_ISSUE);
    res_we    = (r_state == S_WRITE);
    w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
    mux_sel   = '0;
    b_sel     = '0;
    res_idx   = '0;
    if (w_active) begin
      res_idx = r_op;
      b_sel   = r_op;
      // e2 lives on small input 3 and m on the wide input 4 regardless of K
      if (r_op == OP_E2) begin
        mux_sel = 3'd3;
      end else if (r_op == OP_M) begin
        mux_sel = 3'd4;
      end else begin
        mux_sel = r_op;
      end
    end
  end

`ifdef POLY_ADD_TIMEOUT_EN
  logic [9:0] r_wd;
  logic       r_err;

  // Watchdog only runs in WAIT and is cleared everywhere else, so every
  // WAIT entry (and therefore every new start) begins from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_WAIT) begin
        r_wd <= r_wd + 10'd1;
      end else begin
        r_wd <= '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // r_wd == 1022 marks the 1023rd WAIT cycle without add_done
  assign w_timeout = (r_state == S_WAIT) && !add_done && (r_wd == 10'd1022);
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: doc/poly_add_sequencer.md
Name: poly_add_sequencer

Overview:
- Control FSM that runs the Kyber encryption additions through the shared small-polynomial multiplexer and carry-lookahead (CLA) adder.
- Ops in order:
  - u[j] = (A^T r)[j] + e1[j], for j = 0..K-1.
  - v' = t^T r + e2.
  - v = v' + m.
- Drives the mux selector and the operand-B source select, handshakes with the CLA adder, and issues result-write strobes.
- Sits between the encryption top-level FSM and the add datapath.

Parameters:
- K, 3, module rank; legal values 2 or 3, any other value is an elaboration error.
- NUM_OPS, K+2, derived local, total additions per job.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  job request; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until DONE exits
- done  output  1  one-cycle pulse when the job completes
- mux_sel  output  3  selector to the small-poly mux: 0..3 = small inputs, 4 = normal-width input (message m)
- b_sel  output  3  operand-B source: 0..K-1 = (A^T r) row, K = t^T r, K+1 = feedback of previous result v'
- add_start  output  1  one-cycle pulse launching the adder
- add_done  input  1  adder completion pulse
- res_we  output  1  one-cycle result write strobe
- res_idx  output  3  destination: 0..K-1 = u[j], K = v' scratch, K+1 = v
- err  output  1  timeout flag; only active with the optional feature

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - op counter 0.
- Reset asserted mid-job aborts immediately: no further res_we or done, and the adder is not re-launched.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - start=1 -> ISSUE with op=0.
  - start=0 -> stay in IDLE.
- ISSUE:
  - add_start=1 for exactly this cycle.
  - Unconditionally -> WAIT.
  - add_done is ignored in this cycle; the adder latency is >=1.
- WAIT:
  - Hold until add_done=1, then -> WRITE.
  - No limit on wait length without the optional feature.
- WRITE:
  - res_we=1 and res_idx=op for this cycle.
  - If op==NUM_OPS-1 -> DONE; else op+1 -> ISSUE.
- DONE:
  - done=1 for one cycle.
  - -> IDLE. busy drops in the IDLE cycle.
- Per-op mapping, registered and stable from ISSUE through WRITE:
  - op j<K: mux_sel=j, b_sel=j.
  - op K: mux_sel=3 (e2), b_sel=K.
  - op K+1: mux_sel=4 (m), b_sel=K+1.
  - res_idx=op in all cases.
- In IDLE and DONE, mux_sel=0, b_sel=0 and res_idx=0.
- Minimum cycles per op: 3 (ISSUE, one WAIT cycle, WRITE).
- Minimum job length from start sample to done pulse: 3*NUM_OPS+1.
- start while busy is ignored and never queued.
- start high in the DONE cycle is ignored. start still high in the following IDLE cycle launches a new job.
- A spurious add_done outside WAIT is ignored.
- add_done held high for several cycles counts once per WAIT entry.

Optional Feature:
- Macro: POLY_ADD_TIMEOUT_EN.
- When defined:
  - A 10-bit watchdog counts WAIT cycles.
  - If 1023 cycles elapse without add_done: err=1 (sticky until rst), state -> IDLE, no res_we, no done pulse.
  - The next start clears the watchdog but not err.
- When undefined:
  - No watchdog logic.
  - err is tied to 0.
  - WAIT waits indefinitely.

Test Plan:
- Reset then idle: assert rst async mid-cycle -> all outputs 0 immediately; start stays 0 for 10 cycles -> busy=0, no strobes.
- K=3 full job, adder done exactly 1 cycle after each add_start:
  - mux_sel sequence 0,1,2,3,4.
  - b_sel sequence 0,1,2,3,4.
  - res_idx sequence 0,1,2,3,4.
  - Five add_start pulses and five res_we pulses.
  - done exactly 16 cycles after start is sampled.
- K=2 job:
  - mux_sel sequence 0,1,3,4.
  - b_sel sequence 0,1,2,3.
  - res_idx sequence 0,1,2,3.
  - done 13 cycles after start.
- Variable adder latency (1, 7, 3, 20, 2 cycles) plus start pulses while busy plus an add_done pulse during ISSUE:
  - Sequence is unchanged.
  - Extra starts and the stray add_done are ignored.
  - Exactly one done pulse.
- rst asserted during WAIT of op 2 -> outputs 0 immediately; after release, a new start runs a full clean job from op 0.
- With POLY_ADD_TIMEOUT_EN, adder never responds on op 1 -> after 1023 WAIT cycles err=1, state returns to IDLE, only one res_we was seen (op 0), no done.
